// File: rtl/ping_pong_buffer_pkg.sv
// Shared definitions for the ping-pong line buffer.
// Holds size defaults, address-width helper and read FSM states.
package ping_pong_buffer_pkg;

   localparam int DEPTH_DEF = 240;
   localparam int DW_DEF    = 8;

   // Address is {bank, word}: bank select sits in the MSB.
   function automatic int addr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int ADDR_W_DEF = addr_w(DEPTH_DEF);

   typedef enum logic [1:0] {
      R_IDLE,
      R_FETCH,
      R_OUT
   } rd_state_t;

endpackage

// File: rtl/ping_pong_buffer_dp_ram.sv
// Simple dual-port RAM holding both banks, 2*DEPTH words.
// One write port, one registered read port, single clock.
module dp_ram
   import ping_pong_buffer_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DW    = DW_DEF,
   parameter int AW    = ADDR_W_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int LW = AW - 1;
   localparam int IW = $clog2(2 * DEPTH);

   logic [DW-1:0] mem [2*DEPTH];
   logic [IW-1:0] widx;
   logic [IW-1:0] ridx;

   // Bank 1 lives directly after bank 0, so no words are wasted
   // when DEPTH is not a power of two.
   assign widx = waddr[AW-1] ? IW'(DEPTH) + IW'(waddr[LW-1:0])
                             : IW'(waddr[LW-1:0]);
   assign ridx = raddr[AW-1] ? IW'(DEPTH) + IW'(raddr[LW-1:0])
                             : IW'(raddr[LW-1:0]);

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[widx] <= wdata;
   end

   // Registered read; output holds while re is low
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[ridx];
   end

endmodule

// File: rtl/ping_pong_buffer.sv
// Two-bank line buffer: the writer fills one bank while the
// reader drains the other through a valid/ready output.
module ping_pong_buffer
   import ping_pong_buffer_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          data_en,
   input  logic [DW-1:0] data,
   input  logic          rd_ready,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_last,
   output logic [1:0]    bank_full,
   output logic          overflow
);

   localparam int AW = addr_w(DEPTH);
   localparam int LW = AW - 1;
   localparam logic [LW-1:0] LAST = LW'(DEPTH - 1);

   logic          wr_bank;
   logic [LW-1:0] wr_addr;
   logic          wr_ok;
   logic          wr_last;
   logic          rd_bank;
   logic          rd_bank_nxt;
   logic [LW-1:0] rd_addr;
   logic [LW-1:0] rd_addr_nxt;
   rd_state_t     state;
   rd_state_t     state_nxt;
   logic          ram_re;
   logic          clr_full;
   logic [1:0]    set_vec;
   logic [1:0]    clr_vec;
   logic [DW-1:0] ram_q;

   assign wr_ok   = data_en & ~bank_full[wr_bank];
   assign wr_last = (wr_addr == LAST);

   // Write pointer; a full bank drops samples but keeps alignment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_bank  <= 1'b0;
         wr_addr  <= '0;
         overflow <= 1'b0;
      end else if (data_en) begin
         wr_addr <= wr_last ? '0 : wr_addr + LW'(1);
         if (wr_ok && wr_last) wr_bank <= ~wr_bank;
         if (!wr_ok) overflow <= 1'b1;
      end
   end

   // Set/clear requests for the bank full flags
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (wr_ok && wr_last) set_vec[wr_bank] = 1'b1;
      if (clr_full) clr_vec[rd_bank] = 1'b1;
   end

   // Full flags; set and clear never hit the same bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) bank_full <= 2'b00;
      else       bank_full <= (bank_full | set_vec) & ~clr_vec;
   end

   // Read FSM state and pointer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= R_IDLE;
         rd_bank <= 1'b0;
         rd_addr <= '0;
      end else begin
         state   <= state_nxt;
         rd_bank <= rd_bank_nxt;
         rd_addr <= rd_addr_nxt;
      end
   end

   // Read FSM next state: fetch, offer, advance or release bank
   always_comb begin
      state_nxt   = state;
      rd_bank_nxt = rd_bank;
      rd_addr_nxt = rd_addr;
      ram_re      = 1'b0;
      clr_full    = 1'b0;
      unique case (state)
         R_IDLE: begin
            if (bank_full[rd_bank]) begin
               state_nxt   = R_FETCH;
               rd_addr_nxt = '0;
            end
         end
         R_FETCH: begin
            ram_re    = 1'b1;
            state_nxt = R_OUT;
         end
         R_OUT: begin
            if (rd_ready) begin
               if (rd_addr == LAST) begin
                  clr_full    = 1'b1;
                  rd_bank_nxt = ~rd_bank;
                  rd_addr_nxt = '0;
                  state_nxt   = R_IDLE;
               end else begin
                  rd_addr_nxt = rd_addr + LW'(1);
                  state_nxt   = R_FETCH;
               end
            end
         end
         default: state_nxt = R_IDLE;
      endcase
   end

   assign rd_valid = (state == R_OUT);
   assign rd_data  = rd_valid ? ram_q : '0;
   assign rd_last  = rd_valid && (rd_addr == LAST);

   dp_ram #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr ({wr_bank, wr_addr}),
      .wdata (data),
      .re    (ram_re),
      .raddr ({rd_bank, rd_addr}),
      .rdata (ram_q)
   );

endmodule
